// File: rtl/mem_access_stage.sv
// mem_access_stage
//   MEM stage of the five-stage pipeline. Issues loads and stores to a
//   variable-latency data RAM over a req/ack handshake, stalls the upstream
//   pipeline while an access is outstanding, and holds the MEM/WB register.
//
// Ports
//   clk, rst                      clock, asynchronous active-low reset
//   mem_*                         instruction fields from the EX/MEM register
//   mem_stall                     combinational hold request to earlier stages
//   ram_req/we/addr/wdata         registered RAM request
//   ram_rdata/ram_ack             RAM response
//   wb_*                          MEM/WB register outputs
//   mem_error                     sticky error (misaligned, illegal, timeout)
module mem_access_stage #(
  parameter int RAM_ADDR_BITS = 10,
  parameter int ACK_TIMEOUT   = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_ifWriteRegsFile,
  input  logic                     mem_ifWriteMem,
  input  logic                     mem_memOutOrAluOutWriteBackToRegFile,
  input  logic [4:0]               mem_registerWriteAddress,
  input  logic [31:0]              mem_aluOutput,
  input  logic [31:0]              mem_registerRtOrZero,
  output logic                     mem_stall,
  output logic                     ram_req,
  output logic                     ram_we,
  output logic [RAM_ADDR_BITS-1:0] ram_addr,
  output logic [31:0]              ram_wdata,
  input  logic [31:0]              ram_rdata,
  input  logic                     ram_ack,
  output logic                     wb_ifWriteRegsFile,
  output logic                     wb_memOutOrAluOutWriteBackToRegFile,
  output logic [4:0]               wb_registerWriteAddress,
  output logic [31:0]              wb_aluOutput,
  output logic [31:0]              wb_memOutput,
  output logic                     mem_error
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Counter value seen in the last ACCESS cycle before the abort.
  localparam logic [31:0] TIMEOUT_LAST = 32'(ACK_TIMEOUT) - 32'd1;

  state_t      state;
  logic [31:0] timeoutCnt;
  logic [31:0] readBuf;
  logic        aborted;

  logic        memOp;
  logic        misalignedMemOp;
  logic        illegalOp;
  logic        isLoad;
  logic        startAccess;
  logic        timeoutHit;
  logic        wbCapture;
  logic        wbWriteEnNext;
  logic [31:0] wbMemNext;

  // Address bits above the RAM word address are intentionally not decoded.
  logic unusedAddrBits;
  assign unusedAddrBits = ^{mem_aluOutput[31:RAM_ADDR_BITS+2]};

  // Instruction decode and access-start qualification.
  always_comb begin
    memOp           = mem_ifWriteMem | mem_memOutOrAluOutWriteBackToRegFile;
    illegalOp       = mem_ifWriteMem & mem_memOutOrAluOutWriteBackToRegFile;
    isLoad          = mem_memOutOrAluOutWriteBackToRegFile & ~mem_ifWriteMem;
    misalignedMemOp = memOp & (mem_aluOutput[1:0] != 2'b00);
    startAccess     = memOp & ~misalignedMemOp;
  end

  // Timeout detection; a zero ACK_TIMEOUT disables it.
  always_comb begin
    if (ACK_TIMEOUT != 0) begin
      timeoutHit = (timeoutCnt == TIMEOUT_LAST);
    end else begin
      timeoutHit = 1'b0;
    end
  end

  // Stall request and next MEM/WB register contents per state.
  always_comb begin
    mem_stall     = 1'b0;
    wbCapture     = 1'b0;
    wbWriteEnNext = 1'b0;
    wbMemNext     = 32'd0;
    case (state)
      IDLE: begin
        mem_stall     = startAccess;
        wbCapture     = ~startAccess;
        wbWriteEnNext = mem_ifWriteRegsFile & ~illegalOp & ~misalignedMemOp;
        wbMemNext     = 32'd0;
      end
      ACCESS: begin
        mem_stall = 1'b1;
        wbCapture = 1'b0;
      end
      RELEASE: begin
        mem_stall     = 1'b0;
        wbCapture     = 1'b1;
        wbWriteEnNext = mem_ifWriteRegsFile & ~illegalOp & ~aborted;
        // An aborted load never received data, so it forwards zero.
        if (isLoad && !aborted) begin
          wbMemNext = readBuf;
        end else begin
          wbMemNext = 32'd0;
        end
      end
      default: begin
        mem_stall = 1'b0;
        wbCapture = 1'b0;
      end
    endcase
  end

  // Access FSM: RAM request registers, timeout counter, read buffer, error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ram_req    <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= 32'd0;
      timeoutCnt <= 32'd0;
      readBuf    <= 32'd0;
      aborted    <= 1'b0;
      mem_error  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (startAccess) begin
            state      <= ACCESS;
            ram_req    <= 1'b1;
            ram_we     <= mem_ifWriteMem;
            ram_addr   <= mem_aluOutput[RAM_ADDR_BITS+1:2];
            ram_wdata  <= mem_registerRtOrZero;
            timeoutCnt <= 32'd0;
            aborted    <= 1'b0;
          end
          if (misalignedMemOp || illegalOp) begin
            mem_error <= 1'b1;
          end
        end
        ACCESS: begin
          // Ack takes priority over a timeout in the same cycle.
          if (ram_ack) begin
            readBuf <= ram_rdata;
            ram_req <= 1'b0;
            ram_we  <= 1'b0;
            state   <= RELEASE;
          end else if (timeoutHit) begin
            aborted   <= 1'b1;
            ram_req   <= 1'b0;
            ram_we    <= 1'b0;
            mem_error <= 1'b1;
            state     <= RELEASE;
          end else begin
            timeoutCnt <= timeoutCnt + 32'd1;
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          ram_req <= 1'b0;
          ram_we  <= 1'b0;
        end
      endcase
    end
  end

  // MEM/WB pipeline register: captures the instruction or loads a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_ifWriteRegsFile                  <= 1'b0;
      wb_memOutOrAluOutWriteBackToRegFile <= 1'b0;
      wb_registerWriteAddress             <= 5'd0;
      wb_aluOutput                        <= 32'd0;
      wb_memOutput                        <= 32'd0;
    end else if (wbCapture) begin
      wb_ifWriteRegsFile                  <= wbWriteEnNext;
      wb_memOutOrAluOutWriteBackToRegFile <= mem_memOutOrAluOutWriteBackToRegFile;
      wb_registerWriteAddress             <= mem_registerWriteAddress;
      wb_aluOutput                        <= mem_aluOutput;
      wb_memOutput                        <= wbMemNext;
    end else begin
      wb_ifWriteRegsFile                  <= 1'b0;
      wb_memOutOrAluOutWriteBackToRegFile <= 1'b0;
      wb_registerWriteAddress             <= 5'd0;
      wb_aluOutput                        <= 32'd0;
      wb_memOutput                        <= 32'd0;
    end
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline MEM stage for the five-stage CPU. It sits between the EX/MEM pipeline register and the WB stage. It drives loads and stores to a variable-latency data RAM over a req/ack handshake and stalls the upstream pipeline while an access is outstanding. It also contains the MEM/WB pipeline register that feeds write-back.

## Interface
Parameters:
- RAM_ADDR_BITS, default 10: width of the RAM word address.
- ACK_TIMEOUT, default 255: number of ACCESS cycles allowed without an ack before the access is aborted; 0 disables the timeout.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- mem_ifWriteRegsFile  in  1  instruction writes the register file.
- mem_ifWriteMem  in  1  instruction is a store.
- mem_memOutOrAluOutWriteBackToRegFile  in  1  instruction is a load (write-back selects memory data).
- mem_registerWriteAddress  in  5  destination register.
- mem_aluOutput  in  32  ALU result; byte address for loads and stores.
- mem_registerRtOrZero  in  32  store data.
- mem_stall  out  1  combinational; the EX/MEM register and all earlier stages hold while this is 1.
- ram_req  out  1  registered access request.
- ram_we  out  1  registered; 1 = write.
- ram_addr  out  RAM_ADDR_BITS  registered word address, equal to mem_aluOutput[RAM_ADDR_BITS+1:2].
- ram_wdata  out  32  registered write data.
- ram_rdata  in  32  read data, valid in the cycle ram_ack is 1.
- ram_ack  in  1  access complete.
- wb_ifWriteRegsFile  out  1  registered.
- wb_memOutOrAluOutWriteBackToRegFile  out  1  registered.
- wb_registerWriteAddress  out  5  registered.
- wb_aluOutput  out  32  registered.
- wb_memOutput  out  32  registered load data; 0 for non-loads.
- mem_error  out  1  sticky error flag (misalignment, illegal op or timeout); cleared only by reset.

## Operation
- memOp = mem_ifWriteMem | mem_memOutOrAluOutWriteBackToRegFile.
- Both bits set is an illegal op: the store is performed, the register write is suppressed and mem_error is set.
- An address is misaligned when mem_aluOutput[1:0] != 0. A misaligned memOp issues no RAM access, does not stall, sends the WB stage its fields with wb_ifWriteRegsFile = 0, and sets mem_error.
- FSM states are IDLE, ACCESS and RELEASE.
- IDLE, non-memOp or misaligned memOp: mem_stall = 0; the WB register captures the instruction at the edge; stay in IDLE.
- IDLE, aligned memOp: mem_stall = 1; the WB register loads a bubble (all fields 0).
  - Next state is ACCESS.
  - At the same edge ram_req = 1 and ram_we = mem_ifWriteMem; ram_addr and ram_wdata are loaded.
  - The timeout counter clears.
- ACCESS: mem_stall = 1; the WB register loads a bubble.
  - ram_req, ram_we, ram_addr and ram_wdata stay stable until ram_ack is sampled high.
  - On ram_ack: ram_rdata is latched into a read buffer, ram_req drops at that edge, and the next state is RELEASE.
  - If no ack arrives and the counter reaches ACK_TIMEOUT: the access aborts, ram_req drops, mem_error is set, and the next state is RELEASE with the register write suppressed.
  - If ack and timeout occur in the same cycle, the ack wins.
- RELEASE: mem_stall = 0.
  - The WB register captures the instruction fields.
  - wb_memOutput = buffered data for a load, 0 otherwise.
  - wb_ifWriteRegsFile = mem_ifWriteRegsFile unless the access was aborted or illegal.
  - The EX/MEM register advances at the same edge. Next state is IDLE.
- ram_ack outside ACCESS is ignored.

## Timing
- Reset (rst = 0): state goes to IDLE immediately; every registered output is 0; mem_error = 0; the counter and read buffer are cleared. mem_stall then evaluates from the inputs.
- Reset during ACCESS drops ram_req immediately. The RAM must tolerate an abandoned request.
- Non-memory instruction: 1-cycle latency to the wb_* outputs, no stall.
- Memory instruction whose ack arrives in request cycle k (k ≥ 1):
  - mem_stall is high for k+1 cycles;
  - the wb_* outputs are valid k+2 cycles after entry;
  - the instruction costs k+2 cycles in total.
- Timeout: ram_req is high for exactly ACK_TIMEOUT cycles and mem_stall for ACK_TIMEOUT+1 cycles.
- Exactly one non-bubble WB capture happens per instruction. A stalled instruction never writes the register file twice.

## Test plan
- ALU op: ifWriteRegsFile = 1, aluOutput = 0x00001234, writeAddress = 5 -> after the next edge wb_aluOutput = 0x1234, wb_registerWriteAddress = 5, wb_ifWriteRegsFile = 1; mem_stall never high; ram_req stays 0.
- Load from 0x40, ack in the first request cycle with rdata 0xDEADBEEF -> ram_addr = 0x10, ram_we = 0, mem_stall high 2 cycles, then wb_memOutput = 0xDEADBEEF and wb_ifWriteRegsFile = 1 for exactly one cycle.
- Store to 0x8, data 0xCAFEF00D, ack in the 4th request cycle -> ram_we = 1, ram_addr = 0x2, ram_wdata = 0xCAFEF00D held stable for 4 cycles, mem_stall high 5 cycles, wb_ifWriteRegsFile = 0.
- Misaligned load at 0x41 -> ram_req stays 0, no stall, wb_ifWriteRegsFile = 0, mem_error = 1 and it stays 1 through the following good instructions.
- ACK_TIMEOUT = 4 with no ack -> ram_req high 4 cycles then 0, mem_stall high 5 cycles, mem_error = 1, register write suppressed, the next instruction proceeds normally; a late ack is ignored.
- rst driven to 0 mid-ACCESS between clock edges -> ram_req, every wb_* output and mem_error go to 0 without a clock edge; after rst returns to 1 the next load completes normally.
